// File: rtl/pipe_pkg.sv
// pipe_pkg: shared pipeline payload widths and sizing helpers
package pipe_pkg;
  localparam int PIPE_W_DEFAULT = 16;
  localparam int PIPE_W_IF_ID = 16;
  localparam int PIPE_W_ID_RR = 19;
  localparam int PIPE_W_RR_EX = 42;
  localparam int PIPE_W_EX_MA = 38;
  localparam int PIPE_W_MA_WB = 38;
  function automatic int clog2_p1(input int n);
    return $clog2(n + 1);
  endfunction
  function automatic int ptr_w(input int n);
    return n > 1 ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/pipe_wrap_ctr.sv
// pipe_wrap_ctr: modulo-DEPTH pointer with synchronous clear
module pipe_wrap_ctr
  import pipe_pkg::*;
#(
  parameter int DEPTH = 2,
  localparam int PW = ptr_w(DEPTH)
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic          clr,
  input  logic          inc,
  output logic [PW-1:0] ptr
);
  logic [PW-1:0] ptr_q, ptr_d;
  always_comb ptr_d = clr ? '0 : !inc ? ptr_q : ptr_q == PW'(DEPTH - 1) ? '0 : ptr_q + 1'b1;
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) ptr_q <= '0;
    else ptr_q <= ptr_d;
  end
  assign ptr = ptr_q;
endmodule

// File: rtl/pipe_elastic_reg.sv
// pipe_elastic_reg: valid/ready elastic stage register holding up to DEPTH words
module pipe_elastic_reg
  import pipe_pkg::*;
#(
  parameter int WIDTH = PIPE_W_DEFAULT,
  parameter int DEPTH = 2,
  localparam int CW = clog2_p1(DEPTH)
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [CW-1:0]    count,
  output logic [CW-1:0]    peak
);
  localparam int PW = ptr_w(DEPTH);
  logic [CW-1:0] count_q, count_d, peak_q, peak_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PW-1:0] rd_ptr, wr_ptr;
  logic push, pop;
  // ready/valid come only from registered state and flush, never from out_ready
  assign in_ready  = !flush && count_q != CW'(DEPTH);
  assign out_valid = !flush && count_q != '0;
  assign push = in_valid && in_ready;
  assign pop  = out_valid && out_ready;
  pipe_wrap_ctr #(.DEPTH(DEPTH)) u_rd (.clk(clk), .resetn(resetn), .clr(flush), .inc(pop), .ptr(rd_ptr));
  pipe_wrap_ctr #(.DEPTH(DEPTH)) u_wr (.clk(clk), .resetn(resetn), .clr(flush), .inc(push), .ptr(wr_ptr));
  always_comb begin
    count_d = flush ? '0 : push && !pop ? count_q + 1'b1 : pop && !push ? count_q - 1'b1 : count_q;
    peak_d = flush ? '0 : count_d > peak_q ? count_d : peak_q;
    mem_d = mem_q;
    if (push) mem_d[wr_ptr] = in_data;
  end
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      count_q <= '0;
      peak_q  <= '0;
      mem_q   <= '{default: '0};
    end else begin
      count_q <= count_d;
      peak_q  <= peak_d;
      mem_q   <= mem_d;
    end
  end
  assign out_data = mem_q[rd_ptr];
  assign count = count_q;
  assign peak  = peak_q;
endmodule

// File: tb/tb_pipe_elastic_reg.sv
// tb_pipe_elastic_reg: directed vector table plus corner sequences over DEPTH 1..5
module tb_pipe_elastic_reg;
  logic clk = 1'b0;
  logic resetn, flush, in_valid, out_ready;
  logic [15:0] in_data;
  logic rdy [1:5];
  logic vld [1:5];
  logic [15:0] od [1:5];
  logic [2:0] cnt [1:5];
  logic [2:0] pk [1:5];
  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  for (genvar g = 1; g <= 5; g++) begin : g_d
    localparam int CW = $clog2(g + 1);
    logic [CW-1:0] c, p;
    pipe_elastic_reg #(.WIDTH(16), .DEPTH(g)) u_dut (
      .clk(clk), .resetn(resetn), .flush(flush),
      .in_valid(in_valid), .in_ready(rdy[g]), .in_data(in_data),
      .out_valid(vld[g]), .out_ready(out_ready), .out_data(od[g]),
      .count(c), .peak(p)
    );
    assign cnt[g] = 3'(c);
    assign pk[g]  = 3'(p);
  end

  typedef struct {
    int d;
    bit rn, fl, iv;
    logic [15:0] din;
    bit ordy, e_ir, e_ov, ck_od;
    logic [15:0] e_od;
    int e_cnt, e_pk;
  } vec_t;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %0h want %0h", nm, $time, act, exp);
    end
  endtask

  task automatic apply(input vec_t x);
    resetn = x.rn; flush = x.fl; in_valid = x.iv; in_data = x.din; out_ready = x.ordy;
    #1;
    chk("in_ready", 32'(rdy[x.d]), 32'(x.e_ir));
    chk("out_valid", 32'(vld[x.d]), 32'(x.e_ov));
    if (x.ck_od) chk("out_data", 32'(od[x.d]), 32'(x.e_od));
    chk("count", 32'(cnt[x.d]), x.e_cnt);
    chk("peak", 32'(pk[x.d]), x.e_pk);
    @(posedge clk); #1;
  endtask

  task automatic stream(input int d, input int n);
    logic [15:0] q[$];
    logic [15:0] w;
    int sent = 0;
    int got = 0;
    resetn = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    @(posedge clk); #1;
    resetn = 1'b1;
    w = 16'($urandom);
    for (int c = 0; c < 400 && got < n; c++) begin
      in_valid = sent < n; in_data = w; out_ready = 1'($urandom_range(0, 1));
      #1;
      chk("cnt_le_depth", 32'(cnt[d] <= 3'(d)), 1);
      if (vld[d] && out_ready) begin
        chk("rand_nonempty", 32'(q.size() > 0), 1);
        if (q.size() > 0) chk("rand_out", 32'(od[d]), 32'(q.pop_front()));
        got++;
      end
      if (in_valid && rdy[d]) begin
        q.push_back(w);
        sent++;
        w = 16'($urandom);
      end
      @(posedge clk); #1;
    end
    chk("rand_done", got, n);
    in_valid = 1'b0; out_ready = 1'b0;
  endtask

  initial begin
    vec_t v[$];
    logic [15:0] exp_q [4];
    int k;
    resetn = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_data = '0;
    @(posedge clk); #1;
    // d, rn, fl, iv, din, ordy, e_ir, e_ov, ck_od, e_od, e_cnt, e_pk
    v.push_back('{2, 0, 0, 0, 16'h0000, 0, 1, 0, 1, 16'h0000, 0, 0});
    v.push_back('{2, 1, 0, 1, 16'hAAAA, 0, 1, 0, 1, 16'h0000, 0, 0});
    v.push_back('{2, 1, 0, 1, 16'hBBBB, 0, 1, 1, 1, 16'hAAAA, 1, 1});
    v.push_back('{2, 1, 0, 0, 16'h0000, 0, 0, 1, 1, 16'hAAAA, 2, 2});
    v.push_back('{2, 0, 0, 1, 16'hCCCC, 1, 1, 0, 1, 16'h0000, 0, 0});
    v.push_back('{2, 1, 0, 1, 16'h1234, 0, 1, 0, 1, 16'h0000, 0, 0});
    v.push_back('{2, 1, 0, 0, 16'h0000, 0, 1, 1, 1, 16'h1234, 1, 1});
    v.push_back('{2, 1, 0, 0, 16'h0000, 1, 1, 1, 1, 16'h1234, 1, 1});
    v.push_back('{2, 1, 0, 0, 16'h0000, 0, 1, 0, 0, 16'h0000, 0, 1});
    v.push_back('{2, 1, 0, 1, 16'h0011, 0, 1, 0, 0, 16'h0000, 0, 1});
    v.push_back('{2, 1, 0, 1, 16'h0022, 0, 1, 1, 1, 16'h0011, 1, 1});
    v.push_back('{2, 1, 0, 1, 16'h0033, 1, 0, 1, 1, 16'h0011, 2, 2});
    v.push_back('{2, 1, 0, 1, 16'h0033, 1, 1, 1, 1, 16'h0022, 1, 2});
    v.push_back('{2, 1, 0, 0, 16'h0000, 1, 1, 1, 1, 16'h0033, 1, 2});
    v.push_back('{2, 1, 0, 0, 16'h0000, 0, 1, 0, 0, 16'h0000, 0, 2});
    v.push_back('{4, 0, 0, 0, 16'h0000, 0, 1, 0, 1, 16'h0000, 0, 0});
    v.push_back('{4, 1, 0, 1, 16'h0101, 0, 1, 0, 1, 16'h0000, 0, 0});
    v.push_back('{4, 1, 0, 1, 16'h0202, 0, 1, 1, 1, 16'h0101, 1, 1});
    v.push_back('{4, 1, 0, 1, 16'h0303, 0, 1, 1, 1, 16'h0101, 2, 2});
    v.push_back('{4, 1, 1, 1, 16'h0404, 1, 0, 0, 1, 16'h0101, 3, 3});
    v.push_back('{4, 1, 0, 1, 16'h5555, 0, 1, 0, 0, 16'h0000, 0, 0});
    v.push_back('{4, 1, 0, 0, 16'h0000, 1, 1, 1, 1, 16'h5555, 1, 1});
    v.push_back('{4, 1, 0, 0, 16'h0000, 0, 1, 0, 0, 16'h0000, 0, 1});
    foreach (v[i]) apply(v[i]);

    apply('{2, 0, 0, 0, 16'h0000, 0, 1, 0, 1, 16'h0000, 0, 0});
    resetn = 1'b1;
    for (int i = 1; i <= 16; i++) begin
      in_valid = 1'b1; in_data = 16'(i); out_ready = 1'b1;
      #1;
      chk("stream_ir", 32'(rdy[2]), 1);
      if (i > 1) begin
        chk("stream_ov", 32'(vld[2]), 1);
        chk("stream_od", 32'(od[2]), i - 1);
        chk("stream_cnt", 32'(cnt[2]), 1);
      end
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    #1;
    chk("stream_last", 32'(od[2]), 16);
    chk("stream_peak", 32'(pk[2]), 1);
    @(posedge clk); #1;

    apply('{3, 0, 0, 0, 16'h0000, 0, 1, 0, 1, 16'h0000, 0, 0});
    resetn = 1'b1; out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; in_data = 16'hA + 16'(i);
      #1;
      chk("bp_ir", 32'(rdy[3]), 1);
      @(posedge clk); #1;
    end
    in_data = 16'hD;
    #1;
    chk("bp_full_ir", 32'(rdy[3]), 0);
    chk("bp_full_cnt", 32'(cnt[3]), 3);
    @(posedge clk); #1;
    chk("bp_hold_ir", 32'(rdy[3]), 0);
    exp_q = '{16'hA, 16'hB, 16'hC, 16'hD};
    k = 0;
    out_ready = 1'b1;
    for (int c = 0; c < 12 && k < 4; c++) begin
      bit acc;
      #1;
      acc = in_valid && rdy[3];
      if (vld[3]) begin
        chk("bp_order", 32'(od[3]), 32'(exp_q[k]));
        k++;
      end
      @(posedge clk); #1;
      if (acc) in_valid = 1'b0;
    end
    chk("bp_drained", k, 4);
    chk("bp_cnt", 32'(cnt[3]), 0);
    chk("bp_peak", 32'(pk[3]), 3);
    out_ready = 1'b0;

    stream(1, 20);
    stream(5, 20);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/pipe_elastic_reg.md
# pipe_elastic_reg

Parametrised elastic pipeline register that replaces the fixed, always-loading stage registers between pipeline stages. Each instance holds up to DEPTH words of WIDTH bits and moves them with a valid/ready handshake on both sides. It supports a synchronous flush that squashes all in-flight words. Instances sit between IF/ID, ID/RR, RR/EX, EX/MA and MA/WB, so that a stalled downstream stage back-pressures upstream stages without losing instructions.

## Interface
- WIDTH, 16: payload width in bits; legal range 1..64.
- DEPTH, 2: entries held; legal range 1..16, any integer (not restricted to powers of two).
- CW, $clog2(DEPTH+1): width of the occupancy outputs. Derived; never overridden.

- clk  in  1  clock; all state updates on the rising edge.
- resetn  in  1  asynchronous, active-low reset.
- flush  in  1  synchronous squash of all held entries.
- in_valid  in  1  upstream word present.
- in_ready  out  1  block accepts a word this cycle.
- in_data  in  WIDTH  upstream payload.
- out_valid  out  1  head word present.
- out_ready  in  1  downstream consumes the head word this cycle.
- out_data  out  WIDTH  head payload.
- count  out  CW  current occupancy, 0..DEPTH.
- peak  out  CW  highest occupancy since the last reset or flush.

## Operation
- Storage is a circular buffer with read pointer rd_ptr and write pointer wr_ptr.
  - Each pointer wraps from DEPTH-1 to 0.
  - Occupancy is tracked by the count register, not derived from the pointers.
- Ready and valid:
  - in_ready = !flush && (count != DEPTH). It depends only on registered state and flush; there is no combinational path from out_ready.
  - out_valid = !flush && (count != 0).
  - out_data = mem[rd_ptr] at all times.
- A push occurs when in_valid && in_ready. The block writes mem[wr_ptr] and advances wr_ptr.
- A pop occurs when out_valid && out_ready. The block advances rd_ptr.
- Count update:
  - Push only: count+1.
  - Pop only: count-1.
  - Push and pop together: count unchanged, both pointers advance.
- Full: in_ready=0 even if out_ready=1 in the same cycle. The freed slot is usable from the next cycle.
- Empty: out_valid=0. out_data shows stale storage; the bench must not check it.
- Flush has priority over everything:
  - No handshake completes in a flush cycle, because in_ready and out_valid are both forced to 0.
  - Next cycle: count=0, rd_ptr=wr_ptr=0, peak=0.
  - Storage contents are not cleared.
- peak update: next peak = max(peak, next count), evaluated every non-flush cycle.
- in_valid without in_ready: upstream must hold in_data and in_valid stable. The block does not check this.
- Reset (asserted at any time, including mid-transfer):
  - Immediately: count=0, peak=0, pointers=0, out_valid=0.
  - in_ready=1 during reset.
  - All mem entries are 0, so out_data=0.

## Timing
- Latency: a word pushed into an empty block in cycle N is presented with out_valid=1 in cycle N+1.
- Throughput:
  - DEPTH>=2: one word per cycle sustained, with in_ready staying high while out_ready=1.
  - DEPTH=1: alternates, at most one word per two cycles. This is the legal configuration for non-critical stages.
- in_ready falls in the cycle after the push that reaches count=DEPTH.
- in_ready rises in the cycle after the first pop from full.
- flush takes effect in the same cycle (combinational gating) and clears state at the following edge.
- Release of resetn is synchronous to clk. The first handshake is possible on the first rising edge after release.

## Structure
- Shared package pipe_pkg holds:
  - PIPE_W_DEFAULT=16, plus the standard per-stage payload widths (IF/ID 16, ID/RR 19, RR/EX 42, EX/MA 38, MA/WB 38) as localparams.
  - The function clog2_p1 used to derive CW.
- One sub-module, pipe_wrap_ctr:
  - Parameter DEPTH; inputs clk, resetn, clr, inc; output ptr.
  - Modulo-DEPTH pointer with synchronous clear.
  - Instantiated twice, for rd_ptr and wr_ptr.
- Count, peak, storage array and handshake logic live in pipe_elastic_reg.

## Test plan
- Reset with WIDTH=16, DEPTH=2: hold resetn=0 mid-stream with count=2 -> immediately count=0, out_valid=0, in_ready=1, out_data=0; after release, push 0x1234 -> out_valid=1 and out_data=0x1234 next cycle.
- Streaming with DEPTH=2: push 0x0001..0x0010 on consecutive cycles with out_ready=1 -> in_ready never drops, outputs appear in order one cycle delayed, count stays 1, peak=1.
- Back-pressure with DEPTH=3: out_ready=0, push 0xA, 0xB, 0xC, 0xD -> in_ready=0 after the third push and 0xD is held upstream; raise out_ready -> pops 0xA, 0xB, 0xC, 0xD in order, pointers wrap, peak=3.
- Full plus simultaneous pop: at count=DEPTH=2 with in_valid=1 and out_ready=1 -> only the pop occurs, count=1; next cycle push and pop both occur, count stays 1.
- Flush with DEPTH=4: count=3 and flush=1 together with in_valid=1 and out_ready=1 -> no handshake that cycle; next cycle count=0, peak=0, out_valid=0; a following push of 0x5555 exits first.
- DEPTH=1 and DEPTH=5 (non-power-of-two): 20 random words with random out_ready -> output sequence equals input sequence, and count never exceeds DEPTH.
